vst_mem_writer: RTL and testbench
=================================

# vst_mem_writer

Vector store memory writer. Sits directly downstream of the vector store unit: consumes its deshuffled store-operand stream, one VRF word per beat, and turns it into addressed, byte-strobed memory write requests. It also tracks outstanding write responses and reports instruction completion, with a sticky error flag, to the committer once every beat has been acknowledged.

## Interface
Parameters:
- AddrWidth, 32, memory address width.
- MaxOutstanding, 4, maximum write requests issued but not yet responded.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  new store instruction offered.
- req_ready_o  out  1  writer idle and able to accept an instruction.
- req_addr_i  in  AddrWidth  base byte address; low log2(VRFWordWidthB) bits ignored (treated as 0).
- req_vlB_i  in  $bits(vlen_t)  total bytes to store.
- req_insn_id_i  in  insn_id_t  instruction id.
- op_valid_i  in  1  store operand available.
- op_gnt_o  out  1  operand consumed this cycle.
- op_i  in  vrf_data_t  store operand, one VRF word.
- mem_req_valid_o  out  1  write request valid.
- mem_req_ready_i  in  1  memory accepts request.
- mem_addr_o  out  AddrWidth  word-aligned write address.
- mem_wdata_o  out  vrf_data_t  write data.
- mem_wstrb_o  out  vrf_strb_t  byte strobes.
- mem_rsp_valid_i  in  1  one write response.
- mem_rsp_err_i  in  1  response carries error.
- done_o  out  1  single-cycle completion pulse.
- done_insn_id_o  out  insn_id_t  id of completing instruction.
- done_err_o  out  1  any response of the instruction had an error; valid with done_o.

## Operation
- States: IDLE, SEND, DRAIN.
- IDLE: req_ready_o=1. On req_valid_i, latch addr (aligned), vlB, insn_id; clear error flag. Go to SEND if vlB!=0, else DRAIN.
- SEND: mem_req_valid_o = op_valid_i && (outstanding < MaxOutstanding). mem_wdata_o = op_i, mem_addr_o = current address.
- fire = mem_req_valid_o && mem_req_ready_i. op_gnt_o = fire, never otherwise.
- On fire: address += VRFWordWidthB; remaining vlB -= VRFWordWidthB. If remaining <= VRFWordWidthB before the decrement, go to DRAIN.
- mem_wstrb_o: all ones when remaining >= VRFWordWidthB; otherwise only the low `remaining` bytes set.
- Outstanding counter, width GetWidth(MaxOutstanding+1): +1 on fire, -1 on mem_rsp_valid_i. Both in the same cycle leave it unchanged.
- Error flag: set by mem_rsp_valid_i && mem_rsp_err_i; cleared only when a new instruction is accepted.
- DRAIN: when outstanding_q==0, assert done_o, done_insn_id_o = latched id, done_err_o = error flag, then go to IDLE.
- A response while the counter is 0 is a protocol violation: ignore it and flag it with a simulation assertion.
- Address arithmetic wraps modulo 2^AddrWidth silently.

## Timing
- Reset values: state IDLE, req_ready_o=1, all other outputs 0, counters and flags 0.
- op_i to mem_wdata_o, op_valid_i to mem_req_valid_o, and mem_req_ready_i to op_gnt_o are combinational (0 cycles).
- Throughput is one beat per cycle while the operand is valid, ready is high, and outstanding < MaxOutstanding.
- At MaxOutstanding, mem_req_valid_o is held low. A response in that cycle does not unblock the same cycle; it unblocks the next.
- done_o asserts the cycle after the last response is sampled, or the cycle after acceptance when vlB=0. It lasts exactly one cycle.
- A new request is accepted at the earliest in the cycle after done_o.
- Reset mid-operation aborts immediately; in-flight responses arriving after reset are ignored.

## Structure
- core_pkg already supplies vrf_data_t, vrf_strb_t, vlen_t, insn_id_t, VRFWordWidthB, and GetWidth.
- Add to core_pkg: vst_wr_req_t (addr, data, strb) and the state enum vst_wr_state_e.
- One sub-module, vst_strb_gen: combinational, converts remaining vlB into vrf_strb_t. It is reusable by the load path.

## Test plan
Bench configuration: VRFWordWidthB=8, MaxOutstanding=4.
- addr=0x1000, vlB=24, operands always valid, ready always high, responses at +2 cycles -> 3 beats at 0x1000/0x1008/0x1010, all strobes 0xFF, done_o once, done_err_o=0.
- addr=0x2003, vlB=13 -> beats at 0x2000 (strb 0xFF) and 0x2008 (strb 0x1F).
- vlB=64, responses withheld -> exactly 4 beats issued, then stall. Release one response per cycle -> issue resumes a cycle after each; done_o follows the 8th response.
- Second of 3 responses carries an error -> done_err_o=1 with done_o. The next instruction reports done_err_o=0.
- vlB=0 -> no memory requests; done_o the cycle after acceptance.
- Assert rst_ni low after 2 of 5 beats -> all outputs return to reset values and req_ready_o=1. A late response causes no done_o.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared vector core types, plus the store-writer request bundle and state encoding
package core_pkg;

  localparam int unsigned VRFWordWidthB = 8;
  localparam int unsigned VLenWidth     = 16;
  localparam int unsigned InsnIdWidth   = 4;
  localparam int unsigned VstAddrWidth  = 32;

  typedef logic [8*VRFWordWidthB-1:0] vrf_data_t;
  typedef logic [VRFWordWidthB-1:0]   vrf_strb_t;
  typedef logic [VLenWidth-1:0]       vlen_t;
  typedef logic [InsnIdWidth-1:0]     insn_id_t;

  // Bits needed to hold any value in 0 .. n-1.
  function automatic int unsigned GetWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [VstAddrWidth-1:0] addr;
    vrf_data_t               data;
    vrf_strb_t               strb;
  } vst_wr_req_t;

  typedef enum logic [1:0] {
    VST_WR_IDLE,
    VST_WR_SEND,
    VST_WR_DRAIN
  } vst_wr_state_e;

endpackage

// File: rtl/vst_mem_writer_if.sv
// rtl/vst_mem_writer_if.sv - memory write request/response channel of the vector store writer
interface vst_mem_writer_if #(
  parameter int unsigned AddrWidth = 32
) ();
  import core_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [AddrWidth-1:0] addr;
  vrf_data_t            wdata;
  vrf_strb_t            wstrb;
  logic                 rsp_valid;
  logic                 rsp_err;

  modport master (
    output req_valid, addr, wdata, wstrb,
    input  req_ready, rsp_valid, rsp_err
  );

  modport slave (
    input  req_valid, addr, wdata, wstrb,
    output req_ready, rsp_valid, rsp_err
  );

endinterface

// File: rtl/vst_mem_writer_strb_gen.sv
// rtl/vst_mem_writer_strb_gen.sv - vst_strb_gen: remaining byte count to VRF word byte strobes
module vst_strb_gen
  import core_pkg::*;
(
  input  vlen_t     rem_i,
  output vrf_strb_t strb_o
);

  // Byte i is live while more than i bytes remain; saturates to all ones.
  always_comb begin
    strb_o = '0;
    for (int i = 0; i < VRFWordWidthB; i++) begin
      strb_o[i] = (rem_i > vlen_t'(i));
    end
  end

endmodule

// File: rtl/vst_mem_writer.sv
// rtl/vst_mem_writer.sv - turns the store operand stream into strobed memory writes and reports completion
module vst_mem_writer
  import core_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  vlen_t                req_vlB_i,
  input  insn_id_t             req_insn_id_i,
  input  logic                 op_valid_i,
  output logic                 op_gnt_o,
  input  vrf_data_t            op_i,
  vst_mem_writer_if.master     mem,
  output logic                 done_o,
  output insn_id_t             done_insn_id_o,
  output logic                 done_err_o
);

  localparam int unsigned          CntWidth   = GetWidth(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0]  CntMax     = CntWidth'(MaxOutstanding);
  localparam logic [AddrWidth-1:0] OffsetMask = AddrWidth'(VRFWordWidthB - 1);
  localparam logic [AddrWidth-1:0] AddrStep   = AddrWidth'(VRFWordWidthB);
  localparam vlen_t                WordBytes  = vlen_t'(VRFWordWidthB);

  vst_wr_state_e        state_q;
  logic [AddrWidth-1:0] addr_q;
  vlen_t                rem_q;
  insn_id_t             id_q;
  logic                 err_q;
  logic [CntWidth-1:0]  outst_q;

  logic        sending;
  logic        req_valid;
  logic        fire;
  logic        rsp_take;
  vrf_strb_t   strb;
  vst_wr_req_t wr_req;

  assign sending   = (state_q == VST_WR_SEND);
  assign req_valid = sending && op_valid_i && (outst_q < CntMax);
  assign fire      = req_valid && mem.req_ready;
  // Responses with nothing outstanding (e.g. stragglers from before a reset) are dropped.
  assign rsp_take  = mem.rsp_valid && (outst_q != '0);

  vst_strb_gen u_strb_gen (
    .rem_i  (rem_q),
    .strb_o (strb)
  );

  always_comb begin
    wr_req = '0;
    if (sending) begin
      wr_req.addr = VstAddrWidth'(addr_q);
      wr_req.data = op_i;
      wr_req.strb = strb;
    end
  end

  assign mem.req_valid  = req_valid;
  assign mem.addr       = AddrWidth'(wr_req.addr);
  assign mem.wdata      = wr_req.data;
  assign mem.wstrb      = wr_req.strb;
  assign op_gnt_o       = fire;
  assign req_ready_o    = (state_q == VST_WR_IDLE);
  assign done_o         = (state_q == VST_WR_DRAIN) && (outst_q == '0);
  assign done_insn_id_o = done_o ? id_q : '0;
  assign done_err_o     = done_o && err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= VST_WR_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      outst_q <= '0;
    end else begin
      if (fire != rsp_take) begin
        outst_q <= fire ? outst_q + 1'b1 : outst_q - 1'b1;
      end
      if (rsp_take && mem.rsp_err) begin
        err_q <= 1'b1;
      end
      case (state_q)
        VST_WR_IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i & ~OffsetMask;
            rem_q   <= req_vlB_i;
            id_q    <= req_insn_id_i;
            err_q   <= 1'b0;
            state_q <= (req_vlB_i != '0) ? VST_WR_SEND : VST_WR_DRAIN;
          end
        end
        VST_WR_SEND: begin
          if (fire) begin
            addr_q <= addr_q + AddrStep;
            if (rem_q <= WordBytes) begin
              rem_q   <= '0;
              state_q <= VST_WR_DRAIN;
            end else begin
              rem_q <= rem_q - WordBytes;
            end
          end
        end
        VST_WR_DRAIN: begin
          if (outst_q == '0) begin
            state_q <= VST_WR_IDLE;
          end
        end
        default: state_q <= VST_WR_IDLE;
      endcase
    end
  end

  // A response with nothing outstanding while an instruction is active is a memory-side protocol error.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mem.rsp_valid && (state_q != VST_WR_IDLE)) |-> (outst_q != '0));

endmodule

// File: tb/tb_vst_mem_writer.sv
// tb/tb_vst_mem_writer.sv - scoreboard bench for vst_mem_writer
module tb_vst_mem_writer;
  import core_pkg::*;

  typedef struct { logic [31:0] addr; vrf_data_t data; vrf_strb_t strb; } beat_t;
  typedef struct { insn_id_t id; logic err; } done_t;
  typedef struct { int due; logic err; } rsp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  vlen_t       req_vlb = '0;
  insn_id_t    req_id = '0;
  logic        op_valid = 1'b0;
  logic        op_gnt;
  vrf_data_t   op_data = '0;
  logic        done;
  insn_id_t    done_id;
  logic        done_err;

  vst_mem_writer_if #(.AddrWidth(32)) mem_if ();

  vst_mem_writer #(.AddrWidth(32), .MaxOutstanding(4)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_addr_i     (req_addr),
    .req_vlB_i      (req_vlb),
    .req_insn_id_i  (req_id),
    .op_valid_i     (op_valid),
    .op_gnt_o       (op_gnt),
    .op_i           (op_data),
    .mem            (mem_if),
    .done_o         (done),
    .done_insn_id_o (done_id),
    .done_err_o     (done_err)
  );

  beat_t exp_q[$];
  done_t exp_done[$];
  rsp_t  rsp_q[$];

  int total = 0, bad = 0;
  int cyc = 0, fires = 0, dones = 0;
  int opk = 0, op_limit = 0, cur_id = 0, beat_in_insn = 0, err_on_beat = -1;
  int last_rsp_cyc = 0, done_cyc = 0, accept_cyc = 0, first_fire_cyc = 0, last_fire_cyc = 0;
  bit hold_rsp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic vrf_data_t mk_data(input int id, input int k);
    return {8'(id), 8'(k), 16'hC3A5, (32'(k) * 32'h0101_0107) ^ 32'(id * 977)};
  endfunction

  initial forever #5 clk_i = ~clk_i;
  initial forever begin @(posedge clk_i); cyc++; end

  // Operand source and memory responder, driven just after each rising edge.
  initial forever begin
    @(posedge clk_i);
    #1;
    op_valid = (opk < op_limit);
    op_data  = mk_data(cur_id, opk);
    if (!hold_rsp && rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      mem_if.rsp_valid = 1'b1;
      mem_if.rsp_err   = rsp_q[0].err;
      void'(rsp_q.pop_front());
    end else begin
      mem_if.rsp_valid = 1'b0;
      mem_if.rsp_err   = 1'b0;
    end
  end

  // Monitor: scoreboard compare of beats and completions at the falling edge.
  initial forever begin
    beat_t e;
    done_t d;
    rsp_t  r;
    @(negedge clk_i);
    if (rst_ni) begin
      if (mem_if.req_valid && mem_if.req_ready) begin
        fires++;
        chk("op_gnt", 64'(op_gnt), 64'(1));
        chk("beat_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("addr", 64'(mem_if.addr), 64'(e.addr));
          chk("wdata", 64'(mem_if.wdata), 64'(e.data));
          chk("wstrb", 64'(mem_if.wstrb), 64'(e.strb));
        end
        if (beat_in_insn == 0) first_fire_cyc = cyc;
        last_fire_cyc = cyc;
        r.due = cyc + 2;
        r.err = (beat_in_insn == err_on_beat);
        rsp_q.push_back(r);
        beat_in_insn++;
        opk++;
      end else if (op_gnt) begin
        chk("op_gnt_without_fire", 64'(op_gnt), 64'(0));
      end
      if (mem_if.rsp_valid) last_rsp_cyc = cyc;
      if (req_valid && req_ready) accept_cyc = cyc;
      if (done) begin
        dones++;
        done_cyc = cyc;
        chk("done_expected", 64'(exp_done.size() != 0), 64'(1));
        if (exp_done.size() != 0) begin
          d = exp_done.pop_front();
          chk("done_id", 64'(done_id), 64'(d.id));
          chk("done_err", 64'(done_err), 64'(d.err));
        end
      end
    end
  end

  task automatic issue(input logic [31:0] addr, input int vlb, input int id,
                       input int err_beat, input int limit);
    logic [31:0] a;
    int rem, k;
    beat_t b;
    done_t d;
    a = addr & ~32'h7;
    rem = vlb;
    k = 0;
    while (rem > 0) begin
      b.addr = a;
      b.data = mk_data(id, k);
      b.strb = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
      exp_q.push_back(b);
      a += 32'd8;
      rem -= 8;
      k++;
    end
    d.id  = insn_id_t'(id);
    d.err = (err_beat >= 0) && (err_beat < k);
    exp_done.push_back(d);
    @(posedge clk_i);
    #2;
    cur_id = id; opk = 0; beat_in_insn = 0; err_on_beat = err_beat; op_limit = limit;
    req_addr = addr; req_vlb = vlen_t'(vlb); req_id = insn_id_t'(id); req_valid = 1'b1;
    @(posedge clk_i);
    #2;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    int n;
    n = 0;
    while (dones == d0 && n < 300) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    chk({tag, "_done_seen"}, 64'(dones != d0), 64'(1));
  endtask

  initial begin
    int d0, f0, n;
    mem_if.req_ready = 1'b1;
    mem_if.rsp_valid = 1'b0;
    mem_if.rsp_err   = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_mem_valid", 64'(mem_if.req_valid), 64'(0));
    chk("rst_addr", 64'(mem_if.addr), 64'(0));
    chk("rst_wstrb", 64'(mem_if.wstrb), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_done_id", 64'(done_id), 64'(0));
    @(posedge clk_i);
    #2;
    rst_ni = 1'b1;

    // Aligned 3-beat store, full strobes, single-cycle throughput.
    d0 = dones; f0 = fires;
    issue(32'h1000, 24, 1, -1, 99);
    wait_done(d0, "t1");
    chk("t1_beats", 64'(fires - f0), 64'(3));
    chk("t1_tput", 64'(last_fire_cyc - first_fire_cyc), 64'(2));
    chk("t1_done_lat", 64'(done_cyc), 64'(last_rsp_cyc + 1));
    repeat (3) @(negedge clk_i);
    chk("t1_done_once", 64'(dones - d0), 64'(1));

    // Unaligned base, partial tail strobe.
    d0 = dones; f0 = fires;
    issue(32'h2003, 13, 2, -1, 99);
    wait_done(d0, "t2");
    chk("t2_beats", 64'(fires - f0), 64'(2));

    // Outstanding limit stall, then one response per cycle.
    hold_rsp = 1'b1;
    d0 = dones; f0 = fires;
    issue(32'h4000, 64, 3, -1, 99);
    repeat (10) @(negedge clk_i);
    chk("t3_held_beats", 64'(fires - f0), 64'(4));
    chk("t3_stalled", 64'(mem_if.req_valid), 64'(0));
    hold_rsp = 1'b0;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!mem_if.rsp_valid && n < 10);
    chk("t3_rsp_released", 64'(mem_if.rsp_valid), 64'(1));
    chk("t3_no_same_cycle", 64'(mem_if.req_valid), 64'(0));
    @(negedge clk_i);
    chk("t3_resume", 64'(mem_if.req_valid), 64'(1));
    wait_done(d0, "t3");
    chk("t3_beats", 64'(fires - f0), 64'(8));
    chk("t3_done_lat", 64'(done_cyc), 64'(last_rsp_cyc + 1));

    // Error on the second response, then a clean instruction.
    d0 = dones;
    issue(32'h7000, 24, 4, 1, 99);
    wait_done(d0, "t4");
    d0 = dones;
    issue(32'h7100, 16, 5, -1, 99);
    wait_done(d0, "t5");

    // Zero-length store.
    d0 = dones; f0 = fires;
    issue(32'h8000, 0, 6, -1, 99);
    wait_done(d0, "t6");
    chk("t6_beats", 64'(fires - f0), 64'(0));
    chk("t6_done_lat", 64'(done_cyc), 64'(accept_cyc + 1));

    // Reset mid-instruction with responses still in flight.
    hold_rsp = 1'b1;
    f0 = fires;
    issue(32'h5000, 40, 8, -1, 2);
    n = 0;
    while (fires - f0 < 2 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("t7_two_beats", 64'(fires - f0), 64'(2));
    repeat (2) @(negedge clk_i);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t7_req_ready", 64'(req_ready), 64'(1));
    chk("t7_mem_valid", 64'(mem_if.req_valid), 64'(0));
    chk("t7_addr", 64'(mem_if.addr), 64'(0));
    chk("t7_wdata", 64'(mem_if.wdata), 64'(0));
    chk("t7_wstrb", 64'(mem_if.wstrb), 64'(0));
    chk("t7_gnt", 64'(op_gnt), 64'(0));
    chk("t7_done", 64'(done), 64'(0));
    exp_q.delete();
    exp_done.delete();
    repeat (2) @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    d0 = dones;
    hold_rsp = 1'b0;
    repeat (8) @(negedge clk_i);
    chk("t7_late_rsp_no_done", 64'(dones - d0), 64'(0));
    chk("t7_rsp_delivered", 64'(rsp_q.size()), 64'(0));

    // Normal operation after the abort.
    d0 = dones; f0 = fires;
    issue(32'h6004, 8, 9, -1, 99);
    wait_done(d0, "t8");
    chk("t8_beats", 64'(fires - f0), 64'(1));

    repeat (3) @(negedge clk_i);
    chk("end_beats_left", 64'(exp_q.size()), 64'(0));
    chk("end_dones_left", 64'(exp_done.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
